// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage feeding if_id_reg.
// Owns the PC, issues one instruction-memory request at a time over a
// req/ready + rvalid port, buffers the returned instruction and presents it
// (or a NOP bubble) to Decode. Execute-stage redirects may arrive at any time;
// a redirect that races an in-flight request marks that response to be killed.
// Optional feature macro: IFETCH_MISALIGN_EN (misaligned redirect -> FAULT).
module ifetch_stage #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic [31:0]     InstrF,
  output logic            InstrValidF,
  output logic            FetchBusyF,
  output logic            InstrMisalignF
);

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
`ifdef IFETCH_MISALIGN_EN
    ,
    S_FAULT = 2'd3
`endif
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_n;
  logic            kill_q, kill_n;
  logic [31:0]     buf_q, buf_n;
  logic [XLEN-1:0] target;
  logic            accept;

`ifdef IFETCH_MISALIGN_EN
  logic            misaligned;
  assign target     = PCTargetE;
  assign misaligned = |PCTargetE[1:0];
`else
  // Without fault support the low two target bits are simply cleared.
  assign target     = PCTargetE & ~XLEN'(3);
`endif

  assign PCPlus4F       = PCF + XLEN'(4);
  assign imem_req       = (state == S_ISSUE) && !rst;
  assign imem_addr      = PCF;
  assign accept         = imem_req && imem_ready;
  assign InstrValidF    = (state == S_HOLD);
  assign InstrF         = InstrValidF ? buf_q : INSTR_NOP;
  assign FetchBusyF     = (state != S_HOLD);
`ifdef IFETCH_MISALIGN_EN
  assign InstrMisalignF = (state == S_FAULT);
`else
  assign InstrMisalignF = 1'b0;
`endif

  // State register: PC, FSM state, kill flag and instruction buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_ISSUE;
      PCF    <= RESET_PC;
      kill_q <= 1'b0;
      buf_q  <= INSTR_NOP;
    end else begin
      state  <= state_n;
      PCF    <= pc_n;
      kill_q <= kill_n;
      buf_q  <= buf_n;
    end
  end

  // Next-state logic: redirects take priority over StallF everywhere.
  always_comb begin
    state_n = state;
    pc_n    = PCF;
    kill_n  = kill_q;
    buf_n   = buf_q;
    case (state)
      S_ISSUE: begin
        if (PCSrcE) begin
          pc_n = target;
          if (accept) kill_n = 1'b1;
          state_n = accept ? S_WAIT : S_ISSUE;
`ifdef IFETCH_MISALIGN_EN
          if (misaligned) state_n = S_FAULT;
`endif
        end else if (accept) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          pc_n = target;
          if (imem_rvalid) begin
            kill_n  = 1'b0;
            state_n = S_ISSUE;
          end else begin
            kill_n  = 1'b1;
          end
`ifdef IFETCH_MISALIGN_EN
          if (misaligned) state_n = S_FAULT;
`endif
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_n  = 1'b0;
            state_n = S_ISSUE;
          end else begin
            buf_n   = imem_rdata;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_n    = target;
          state_n = S_ISSUE;
`ifdef IFETCH_MISALIGN_EN
          if (misaligned) state_n = S_FAULT;
`endif
        end else if (!StallF) begin
          pc_n    = PCPlus4F;
          state_n = S_ISSUE;
        end
      end
`ifdef IFETCH_MISALIGN_EN
      S_FAULT: begin
        if (kill_q && imem_rvalid) kill_n = 1'b0;
        if (PCSrcE) begin
          pc_n = target;
          if (!misaligned)
            state_n = (kill_q && !imem_rvalid) ? S_WAIT : S_ISSUE;
        end
      end
`endif
      default: state_n = S_ISSUE;
    endcase
  end

  // A response is only legal while a request is outstanding.
  rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (state == S_ISSUE || state == S_HOLD)));

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed, self-checking bench for ifetch_stage.
// Define IFETCH_MISALIGN_EN for both files to exercise the FAULT path.
module tb_ifetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, PCPlus4F, InstrF;
  logic        InstrValidF, FetchBusyF, InstrMisalignF;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  ifetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .InstrValidF(InstrValidF),
    .FetchBusyF(FetchBusyF), .InstrMisalignF(InstrMisalignF)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic pcsrc, input logic [31:0] tgt,
                               input logic stall, input logic ready,
                               input logic rvalid, input logic [31:0] rdata);
    PCSrcE      = pcsrc;
    PCTargetE   = tgt;
    StallF      = stall;
    imem_ready  = ready;
    imem_rvalid = rvalid;
    imem_rdata  = rdata;
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed test sequence.
  initial begin
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    tick();
    $display("[TB] reset");
    checkOutput("rst_req",      32'(imem_req), 32'd0);
    checkOutput("rst_pc",       PCF, 32'h0);
    checkOutput("rst_valid",    32'(InstrValidF), 32'd0);
    checkOutput("rst_instr",    InstrF, NOP);
    checkOutput("rst_busy",     32'(FetchBusyF), 32'd1);
    checkOutput("rst_misalign", 32'(InstrMisalignF), 32'd0);

    $display("[TB] first fetch");
    rst = 1'b0;
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("f1_req",   32'(imem_req), 32'd1);
    checkOutput("f1_addr",  imem_addr, 32'h0);
    checkOutput("f1_plus4", PCPlus4F, 32'h4);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 1, 32'h0050_0093);
    checkOutput("f1_wait_req",   32'(imem_req), 32'd0);
    checkOutput("f1_wait_valid", 32'(InstrValidF), 32'd0);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("f1_instr", InstrF, 32'h0050_0093);
    checkOutput("f1_valid", 32'(InstrValidF), 32'd1);
    checkOutput("f1_busy",  32'(FetchBusyF), 32'd0);
    checkOutput("f1_pc",    PCF, 32'h0);
    tick();
    checkOutput("f2_req",   32'(imem_req), 32'd1);
    checkOutput("f2_addr",  imem_addr, 32'h4);
    checkOutput("f2_pc",    PCF, 32'h4);
    checkOutput("f2_valid", 32'(InstrValidF), 32'd0);
    checkOutput("f2_plus4", PCPlus4F, 32'h8);

    $display("[TB] stall in HOLD");
    tick();
    applyStimulus(0, 32'h0, 0, 1, 1, 32'h00A0_0113);
    tick();
    applyStimulus(0, 32'h0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_pc",    PCF, 32'h4);
      checkOutput("stall_instr", InstrF, 32'h00A0_0113);
      checkOutput("stall_valid", 32'(InstrValidF), 32'd1);
      checkOutput("stall_req",   32'(imem_req), 32'd0);
      tick();
    end
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("stall_end_valid", 32'(InstrValidF), 32'd1);
    tick();
    checkOutput("post_stall_addr", imem_addr, 32'h8);

    $display("[TB] redirect while WAIT");
    tick();
    applyStimulus(1, 32'h100, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("rdw_req", 32'(imem_req), 32'd0);
    checkOutput("rdw_pc",  PCF, 32'h100);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 1, 32'h0000_DEAD);
    checkOutput("rdw_valid0", 32'(InstrValidF), 32'd0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("rdw_valid1", 32'(InstrValidF), 32'd0);
    checkOutput("rdw_req2",   32'(imem_req), 32'd1);
    checkOutput("rdw_addr",   imem_addr, 32'h100);

    $display("[TB] ready held low");
    for (int i = 0; i < 4; i++) begin
      checkOutput("nrdy_req",  32'(imem_req), 32'd1);
      checkOutput("nrdy_addr", imem_addr, 32'h100);
      tick();
    end
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("nrdy_req5", 32'(imem_req), 32'd1);
    tick();
    checkOutput("nrdy_wait", 32'(imem_req), 32'd0);

    $display("[TB] redirect beats stall in HOLD");
    applyStimulus(0, 32'h0, 0, 1, 1, 32'h0000_0033);
    tick();
    applyStimulus(1, 32'h200, 1, 1, 0, 32'h0);
    checkOutput("rsh_instr", InstrF, 32'h0000_0033);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("rsh_pc",    PCF, 32'h200);
    checkOutput("rsh_valid", 32'(InstrValidF), 32'd0);
    checkOutput("rsh_addr",  imem_addr, 32'h200);

    $display("[TB] redirect on accepted issue");
    applyStimulus(1, 32'h300, 0, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 1, 32'h0000_BEEF);
    checkOutput("rai_req", 32'(imem_req), 32'd0);
    checkOutput("rai_pc",  PCF, 32'h300);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("rai_valid", 32'(InstrValidF), 32'd0);
    checkOutput("rai_addr",  imem_addr, 32'h300);

    $display("[TB] redirect on unaccepted issue");
    applyStimulus(1, 32'h400, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("rni_req",  32'(imem_req), 32'd1);
    checkOutput("rni_addr", imem_addr, 32'h400);

    $display("[TB] redirect with rvalid in WAIT");
    tick();
    applyStimulus(1, 32'h500, 0, 0, 1, 32'h0000_1234);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("rwv_valid", 32'(InstrValidF), 32'd0);
    checkOutput("rwv_req",   32'(imem_req), 32'd1);
    checkOutput("rwv_addr",  imem_addr, 32'h500);

    $display("[TB] PC wrap");
    applyStimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("wrap_pc",    PCF, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", PCPlus4F, 32'h0);

    $display("[TB] misaligned redirect");
    applyStimulus(1, 32'h102, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
`ifdef IFETCH_MISALIGN_EN
    checkOutput("mis_flag", 32'(InstrMisalignF), 32'd1);
    checkOutput("mis_pc",   PCF, 32'h102);
    checkOutput("mis_req",  32'(imem_req), 32'd0);
    checkOutput("mis_busy", 32'(FetchBusyF), 32'd1);
    tick();
    checkOutput("mis_hold_flag", 32'(InstrMisalignF), 32'd1);
    checkOutput("mis_hold_req",  32'(imem_req), 32'd0);
    applyStimulus(1, 32'h200, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("mis_clr_flag", 32'(InstrMisalignF), 32'd0);
    checkOutput("mis_clr_req",  32'(imem_req), 32'd1);
    checkOutput("mis_clr_addr", imem_addr, 32'h200);
`else
    checkOutput("mis_flag", 32'(InstrMisalignF), 32'd0);
    checkOutput("mis_pc",   PCF, 32'h100);
    checkOutput("mis_req",  32'(imem_req), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
